path_delay_sequencer: RTL and testbench
=======================================

Name: path_delay_sequencer

Overview:
- Sequences delay measurement over NUM_PATHS replicated delay-chain instances for delay-based trojan detection.
- For each path in turn it does four things:
  - parks the path input low and waits for the output to settle low;
  - launches a rising edge into the path;
  - counts clock cycles until the synchronised path output rises;
  - repeats 2^TRIALS_LOG2 trials and reports the averaged delay.
- Sits between the path array and the host/UART reporting logic.

Parameters:
- NUM_PATHS, 4, number of delay paths driven and observed.
- CNT_W, 16, width of per-trial cycle counter and reported delay.
- TRIALS_LOG2, 3, log2 of trials averaged per path (8 trials).
- SETTLE_CYC, 16, minimum low-park cycles before each launch.
- TIMEOUT, 1000, cycle limit for settle and for measure; must be < 2^CNT_W - 1.
- SYNC_STAGES, 2, flip-flop stages synchronising each path_result bit.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; begins a full sweep when idle.
- path_input, out, NUM_PATHS, launch drive per path; only the selected bit can be 1.
- path_result, in, NUM_PATHS, raw asynchronous path outputs.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse after the last path is reported.
- result_valid, out, 1, one-cycle pulse per path.
- result_path, out, clog2(NUM_PATHS) (min 1), index of the reported path.
- result_delay, out, CNT_W, averaged delay in cycles; all-ones on timeout.
- result_timeout, out, 1, the reported path failed to settle or to rise.

Behaviour:
- Reset (async, rst_n=0): state IDLE; path_input=0; busy, done, result_valid, result_timeout=0; result_path=0; result_delay=0; counters, accumulator and sync chains cleared. Reset mid-sweep aborts immediately; the path drive drops in the same instant.
- Sync: each path_result bit passes through SYNC_STAGES flops; sync_res = last stage of the selected path.
- FSM states: IDLE, SETTLE, LAUNCH, MEASURE, ACCUM, REPORT, DONE.
- IDLE: start=1 -> path idx=0, trial=0, accumulator=0, busy=1, go to SETTLE. start is ignored while busy.
- SETTLE: path_input=0.
  - Count up each cycle.
  - Leave when count >= SETTLE_CYC-1 and sync_res==0 -> LAUNCH.
  - If count reaches TIMEOUT with sync_res still 1 -> timeout flag, go to REPORT.
- LAUNCH: one cycle. Set path_input[idx]=1 (registered), clear cnt to 0 -> MEASURE.
- MEASURE: path_input[idx] held at 1; cnt increments every cycle.
  - First cycle with sync_res==1 -> ACCUM; the cnt value in that cycle is the trial delay (includes sync latency).
  - cnt==TIMEOUT -> timeout flag, go to REPORT.
- ACCUM: accumulator (CNT_W+TRIALS_LOG2 bits, no overflow possible) += delay; path_input=0.
  - trial == 2^TRIALS_LOG2-1 -> REPORT.
  - Otherwise trial+1 -> SETTLE.
- REPORT: one-cycle result_valid=1 with result_path=idx.
  - result_delay = accumulator >> TRIALS_LOG2 (truncating).
  - On timeout: result_delay = all-ones and result_timeout=1; remaining trials for that path are skipped.
  - Then clear accumulator, trial and timeout flag. Last path -> DONE; otherwise idx+1 -> SETTLE.
- DONE: done=1 for one cycle, busy=0 in the following cycle -> IDLE.
- result_path, result_delay and result_timeout hold their values until the next REPORT.
- path_input is one-hot or zero at all times, and all zero outside LAUNCH/MEASURE.

Test Plan:
- Path model returns rise 5 cycles after launch on every path; pulse start -> 4 result_valid pulses, paths 0..3, result_delay = 5+SYNC_STAGES±1 fixed value, result_timeout=0, then one done pulse.
- Path 2 delays alternate 10/12 across trials -> path 2 result_delay = (sum of 8 measured counts)>>3; the value is checked exactly against the model count.
- Path 1 output stuck at 0 -> path 1 reports result_timeout=1 and result_delay=16'hFFFF after TIMEOUT cycles of MEASURE; paths 2..3 still measured normally.
- Path 3 output stuck at 1 -> SETTLE times out; path 3 reports a timeout and path_input[3] is never asserted.
- start pulsed again during MEASURE -> ignored, sweep completes with exactly 4 reports.
- rst_n low mid-MEASURE on path 1 -> path_input=0 and busy=0 immediately; after release, a new start sweep begins from path 0.

Source files
------------

// File: rtl/path_delay_sequencer.sv
// path_delay_sequencer: sweeps NUM_PATHS replicated delay chains, launching
// 2^TRIALS_LOG2 rising edges into each one and reporting the averaged number
// of clock cycles until the synchronised output rises.
module path_delay_sequencer #(
   parameter int unsigned NUM_PATHS   = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TRIALS_LOG2 = 3,
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned IDX_W      = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   output logic [NUM_PATHS-1:0] o_path_input,
   input  logic [NUM_PATHS-1:0] i_path_result,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_result_valid,
   output logic [IDX_W-1:0]     o_result_path,
   output logic [CNT_W-1:0]     o_result_delay,
   output logic                 o_result_timeout
);

   localparam int unsigned ACC_W = CNT_W + TRIALS_LOG2;
   localparam int unsigned TR_W  = (TRIALS_LOG2 > 0) ? TRIALS_LOG2 : 1;

   localparam logic [CNT_W-1:0] SETTLE_MIN = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
   localparam logic [TR_W-1:0]  LAST_TRIAL = TR_W'((1 << TRIALS_LOG2) - 1);
   localparam logic [IDX_W-1:0] LAST_PATH  = IDX_W'(NUM_PATHS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_LAUNCH,
      S_MEASURE,
      S_ACCUM,
      S_REPORT,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [TR_W-1:0]      r_trial;
   logic [CNT_W-1:0]     r_cnt;
   logic [ACC_W-1:0]     r_acc;
   logic [NUM_PATHS-1:0] r_sync [SYNC_STAGES];

   logic                 w_sync_res;
   logic [NUM_PATHS-1:0] w_onehot;
   logic [ACC_W-1:0]     w_acc_sum;
   logic [CNT_W-1:0]     w_avg;

   assign w_sync_res = r_sync[SYNC_STAGES-1][r_idx];
   assign w_acc_sum  = r_acc + ACC_W'(r_cnt);
   // Averaging is a plain truncating shift of the sum including this trial.
   assign w_avg      = w_acc_sum[ACC_W-1 -: CNT_W];

   // Launch mask: single bit for the currently selected path.
   always_comb begin
      w_onehot = '0;
      for (int unsigned p = 0; p < NUM_PATHS; p++) begin
         if (r_idx == IDX_W'(p)) w_onehot[p] = 1'b1;
      end
   end

   // Metastability synchronisers for every raw path output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= i_path_result;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   // Sequencer FSM; result outputs are loaded on the transition into REPORT
   // so result_valid coincides with the REPORT state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= S_IDLE;
         r_idx            <= '0;
         r_trial          <= '0;
         r_cnt            <= '0;
         r_acc            <= '0;
         o_path_input     <= '0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_result_valid   <= 1'b0;
         o_result_path    <= '0;
         o_result_delay   <= '0;
         o_result_timeout <= 1'b0;
      end else begin
         o_done         <= 1'b0;
         o_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_idx   <= '0;
                  r_trial <= '0;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  o_busy  <= 1'b1;
                  r_state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if ((r_cnt >= SETTLE_MIN) && !w_sync_res) begin
                  r_state <= S_LAUNCH;
               end else if (r_cnt >= CNT_LIMIT) begin
                  o_result_valid   <= 1'b1;
                  o_result_path    <= r_idx;
                  o_result_delay   <= '1;
                  o_result_timeout <= 1'b1;
                  r_state          <= S_REPORT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_LAUNCH: begin
               o_path_input <= w_onehot;
               r_cnt        <= '0;
               r_state      <= S_MEASURE;
            end
            S_MEASURE: begin
               if (w_sync_res) begin
                  o_path_input <= '0;
                  r_state      <= S_ACCUM;
               end else if (r_cnt == CNT_LIMIT) begin
                  o_path_input     <= '0;
                  o_result_valid   <= 1'b1;
                  o_result_path    <= r_idx;
                  o_result_delay   <= '1;
                  o_result_timeout <= 1'b1;
                  r_state          <= S_REPORT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ACCUM: begin
               r_acc <= w_acc_sum;
               r_cnt <= '0;
               if (r_trial == LAST_TRIAL) begin
                  o_result_valid   <= 1'b1;
                  o_result_path    <= r_idx;
                  o_result_delay   <= w_avg;
                  o_result_timeout <= 1'b0;
                  r_state          <= S_REPORT;
               end else begin
                  r_trial <= r_trial + TR_W'(1);
                  r_state <= S_SETTLE;
               end
            end
            S_REPORT: begin
               r_acc   <= '0;
               r_trial <= '0;
               r_cnt   <= '0;
               if (r_idx == LAST_PATH) begin
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= S_SETTLE;
               end
            end
            S_DONE: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               o_path_input <= '0;
               o_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_path_delay_sequencer.sv
// Bench for path_delay_sequencer: a behavioural path model answers each launch
// after a programmed number of cycles (or sticks low/high); sweep scenarios are
// described in a table of per-path model settings and expected reports.
module tb_path_delay_sequencer;

   localparam int NP   = 4;
   localparam int SYNC = 2;
   localparam int NVEC = 5;
   localparam int SWEEP_LIMIT = 20000;

   localparam logic [1:0] M_NORM = 2'd0;
   localparam logic [1:0] M_ST0  = 2'd1;
   localparam logic [1:0] M_ST1  = 2'd2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [NP-1:0] path_input;
   logic [NP-1:0] path_result;
   logic          busy;
   logic          done;
   logic          result_valid;
   logic [1:0]    result_path;
   logic [15:0]   result_delay;
   logic          result_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   path_delay_sequencer #(
      .NUM_PATHS   (NP),
      .CNT_W       (16),
      .TRIALS_LOG2 (3),
      .SETTLE_CYC  (16),
      .TIMEOUT     (1000),
      .SYNC_STAGES (SYNC)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_start          (start),
      .o_path_input     (path_input),
      .i_path_result    (path_result),
      .o_busy           (busy),
      .o_done           (done),
      .o_result_valid   (result_valid),
      .o_result_path    (result_path),
      .o_result_delay   (result_delay),
      .o_result_timeout (result_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Path model configuration (written by the stimulus process only)
   logic [NP-1:0][1:0] m_mode;
   logic [NP-1:0][7:0] m_d0;
   logic [NP-1:0][7:0] m_d1;

   // Path model: output rises at the D-th falling edge on which the path input
   // is seen high; odd-numbered launches use d0, even-numbered use d1.
   // With the registered launch and SYNC flops the DUT count is D + SYNC - 1.
   int age [NP];
   int launches [NP];
   initial begin
      path_result = '0;
      for (int p = 0; p < NP; p++) begin
         age[p]      = 0;
         launches[p] = 0;
      end
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            logic nr;
            if (!busy) launches[p] = 0;
            if (path_input[p]) begin
               if (age[p] == 0) launches[p]++;
               age[p]++;
               nr = (age[p] >= ((launches[p] % 2 == 1) ? int'(m_d0[p]) : int'(m_d1[p])));
            end else begin
               age[p] = 0;
               nr     = 1'b0;
            end
            if (m_mode[p] == M_ST1)      path_result[p] = 1'b1;
            else if (m_mode[p] == M_ST0) path_result[p] = 1'b0;
            else                         path_result[p] = nr;
         end
      end
   end

   typedef struct {
      logic [NP-1:0][1:0]  mode;
      logic [NP-1:0][7:0]  d0;
      logic [NP-1:0][7:0]  d1;
      logic [NP-1:0][15:0] exp_delay;
      logic [NP-1:0]       exp_to;
      logic [NP-1:0]       forbid_pi;
      bit                  poke_start;
   } vec_t;

   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_path(input int vi, input int p, input logic [1:0] mode,
                           input int d0, input int d1, input int expd, input logic expto);
      vecs[vi].mode[p]      = mode;
      vecs[vi].d0[p]        = 8'(d0);
      vecs[vi].d1[p]        = 8'(d1);
      vecs[vi].exp_delay[p] = 16'(expd);
      vecs[vi].exp_to[p]    = expto;
   endtask

   task automatic run_sweep(input int vi);
      vec_t          v;
      int            nrep;
      int            cyc;
      bit            done_seen;
      bit            poked;
      bit            oh_bad;
      logic [NP-1:0] pi_seen;
      v         = vecs[vi];
      nrep      = 0;
      cyc       = 0;
      done_seen = 0;
      poked     = 0;
      oh_bad    = 0;
      pi_seen   = '0;
      m_mode    = v.mode;
      m_d0      = v.d0;
      m_d1      = v.d1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d busy after start", vi), 32'(busy), 32'd1);
      while (!done_seen && cyc < SWEEP_LIMIT) begin
         @(negedge clk);
         cyc++;
         pi_seen |= path_input;
         if (!$onehot0(path_input)) oh_bad = 1;
         if (v.poke_start && !poked && path_input != '0) begin
            start = 1'b1;
            poked = 1;
         end else begin
            start = 1'b0;
         end
         if (result_valid) begin
            if (nrep < NP) begin
               check($sformatf("v%0d rpt%0d path", vi, nrep), 32'(result_path), 32'(nrep));
               check($sformatf("v%0d rpt%0d delay", vi, nrep), 32'(result_delay), 32'(v.exp_delay[nrep]));
               check($sformatf("v%0d rpt%0d timeout", vi, nrep), 32'(result_timeout), 32'(v.exp_to[nrep]));
            end
            nrep++;
         end
         if (done) begin
            done_seen = 1;
            check($sformatf("v%0d busy at done", vi), 32'(busy), 32'd1);
         end
      end
      start = 1'b0;
      check($sformatf("v%0d done seen", vi), 32'(done_seen), 32'd1);
      check($sformatf("v%0d report count", vi), 32'(nrep), 32'(NP));
      @(negedge clk);
      check($sformatf("v%0d busy after done", vi), 32'(busy), 32'd0);
      check($sformatf("v%0d done one cycle", vi), 32'(done), 32'd0);
      check($sformatf("v%0d held path", vi), 32'(result_path), 32'(NP - 1));
      check($sformatf("v%0d held delay", vi), 32'(result_delay), 32'(v.exp_delay[NP-1]));
      check($sformatf("v%0d path_input onehot0", vi), 32'(oh_bad), 32'd0);
      check($sformatf("v%0d forbidden launch", vi), 32'(pi_seen & v.forbid_pi), 32'd0);
   endtask

   initial begin
      // Defaults: all paths normal, no forbidden launches, no mid-sweep start
      for (int i = 0; i < NVEC; i++) begin
         vecs[i].forbid_pi  = '0;
         vecs[i].poke_start = 0;
         for (int p = 0; p < NP; p++) set_path(i, p, M_NORM, 5, 5, 5 + SYNC - 1, 1'b0);
      end
      // v0: every path rises 5 cycles after launch -> 6
      // v1: mixed delays; path 2 alternates 10/12 -> (4*11 + 4*13) >> 3 = 12
      set_path(1, 0, M_NORM,  3,  3,  4, 1'b0);
      set_path(1, 1, M_NORM,  7,  7,  8, 1'b0);
      set_path(1, 2, M_NORM, 10, 12, 12, 1'b0);
      set_path(1, 3, M_NORM, 20, 20, 21, 1'b0);
      // v2: path 1 stuck low -> measure timeout
      set_path(2, 1, M_ST0,   5,  5, 16'hFFFF, 1'b1);
      // v3: path 3 stuck high -> settle timeout, never launched;
      //     path 0 alternates 4/5 -> (4*5 + 4*6) >> 3 = 5 (truncated 5.5)
      set_path(3, 0, M_NORM,  4,  5,  5, 1'b0);
      set_path(3, 1, M_NORM,  4,  4,  5, 1'b0);
      set_path(3, 2, M_NORM,  4,  4,  5, 1'b0);
      set_path(3, 3, M_ST1,   4,  4, 16'hFFFF, 1'b1);
      vecs[3].forbid_pi = 4'b1000;
      // v4: delay 6 -> 7, start pulsed again during the first MEASURE
      for (int p = 0; p < NP; p++) set_path(4, p, M_NORM, 6, 6, 7, 1'b0);
      vecs[4].poke_start = 1;

      m_mode = '0;
      m_d0   = '0;
      m_d1   = '0;
      start  = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      check("reset path_input", 32'(path_input), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset valid", 32'(result_valid), 32'd0);
      check("reset result_path", 32'(result_path), 32'd0);
      check("reset result_delay", 32'(result_delay), 32'd0);
      check("reset timeout", 32'(result_timeout), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle without start", 32'(busy), 32'd0);

      for (int i = 0; i < NVEC; i++) run_sweep(i);

      // Reset in the middle of measuring path 1
      begin
         int  cyc;
         bit  hit;
         cyc = 0;
         hit = 0;
         m_mode = '0;
         for (int p = 0; p < NP; p++) begin
            m_d0[p] = 8'd50;
            m_d1[p] = 8'd50;
         end
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (!hit && cyc < SWEEP_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (path_input[1]) hit = 1;
         end
         check("mid-reset reached path 1 measure", 32'(hit), 32'd1);
         rst_n = 1'b0;
         #1;
         check("mid-reset path_input", 32'(path_input), 32'd0);
         check("mid-reset busy", 32'(busy), 32'd0);
         check("mid-reset result_delay", 32'(result_delay), 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (2) @(negedge clk);
         check("post-reset idle", 32'(busy), 32'd0);
      end
      run_sweep(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
